// File: rtl/key_pkg.sv
// Shared definitions for the key click classifier: event type encoding and the
// per-key click FSM state.
package key_pkg;

  localparam logic EVT_SINGLE = 1'b0;
  localparam logic EVT_DOUBLE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } click_state_e;

endpackage

// File: rtl/key_click_classifier_click_fsm.sv
// Per-key click FSM: turns a pulse sequence into one single/double event strobe
// using a window counter that starts at the first press.
module click_fsm
  import key_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CW     = $clog2(WINDOW)
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic evt_stb_o,
  output logic evt_type_o
);

  click_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A second press on the final window cycle still counts as a double.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_stb_o  = 1'b0;
    evt_type_o = EVT_SINGLE;
    case (state_q)
      IDLE: begin
        if (pulse_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (pulse_i) begin
          evt_stb_o  = 1'b1;
          evt_type_o = EVT_DOUBLE;
          state_d    = IDLE;
        end else if (cnt_q == CW'(WINDOW - 1)) begin
          evt_stb_o  = 1'b1;
          evt_type_o = EVT_SINGLE;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/key_click_classifier.sv
// Classifies debounced key presses into single/double clicks and serialises the
// events of all keys into one valid/ready stream with a sticky drop flag.
module key_click_classifier
  import key_pkg::*;
#(
  parameter int N      = 1,
  parameter int WINDOW = 3_000_000,
  parameter int CW     = $clog2(WINDOW),
  parameter int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  key_pulse,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [IW-1:0] evt_key,
  output logic          evt_double,
  output logic          ovf,
  input  logic          ovf_clr
);

  // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
  // while evt_valid is high and evt_ready low, evt_key/evt_double do not change.

  logic [N-1:0]  stb, typ;
  logic [N-1:0]  pv_q, pv_d, pt_q, pt_d, drain;
  logic          sel_valid, sel_type, load, drop;
  logic [IW-1:0] sel_idx;
  logic          valid_q, valid_d, dbl_q, dbl_d, ovf_q, ovf_d;
  logic [IW-1:0] key_q, key_d;

  for (genvar g = 0; g < N; g++) begin : g_fsm
    click_fsm #(
      .WINDOW (WINDOW),
      .CW     (CW)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .pulse_i    (key_pulse[g]),
      .evt_stb_o  (stb[g]),
      .evt_type_o (typ[g])
    );
  end

  // Fixed priority: scanning downwards leaves the lowest pending index selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_type  = EVT_SINGLE;
    for (int i = N - 1; i >= 0; i--) begin
      if (pv_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        sel_type  = pt_q[i];
      end
    end
  end

  assign load = !valid_q || evt_ready;

  // A slot being drained this cycle can take a new event in the same edge.
  always_comb begin
    pv_d  = pv_q;
    pt_d  = pt_q;
    drain = '0;
    drop  = 1'b0;
    for (int i = 0; i < N; i++) begin
      drain[i] = load && sel_valid && (sel_idx == IW'(i));
      if (drain[i]) pv_d[i] = 1'b0;
      if (stb[i]) begin
        if (!pv_q[i] || drain[i]) begin
          pv_d[i] = 1'b1;
          pt_d[i] = typ[i];
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    dbl_d   = dbl_q;
    if (load) begin
      valid_d = sel_valid;
      if (sel_valid) begin
        key_d = sel_idx;
        dbl_d = sel_type;
      end
    end
    ovf_d = ovf_clr ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q    <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
      key_q   <= '0;
      dbl_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pv_q    <= pv_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      dbl_q   <= dbl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_key    = key_q;
  assign evt_double = dbl_q;
  assign ovf        = ovf_q;

endmodule
